dpc_console_io: RTL and testbench
=================================

Name: dpc_console_io

Overview:
Console I/O responder on the CPU side of the Cout/CinReq/CioAcq handshake. It services output requests by turning the BCD accumulator into a byte and pushing it to a byte-stream sink (UART TX). It services input requests by popping a buffered byte from a byte-stream source (UART RX) and presenting it as BCD on DataCin. It sits between the DekatronPC core and the board UART or emulator console.

Parameters:
DATA_DIGITS, 3, number of BCD digits in Data/DataCin (matches DATA_DEKATRON_NUM)
DIGIT_WIDTH, 4, bits per BCD digit (matches DEKATRON_WIDTH)
RX_DEPTH, 4, input type-ahead FIFO depth in bytes; power of 2, at least 2

Ports:
Clk  input  1  system clock; all logic on the rising edge
Rst_n  input  1  asynchronous active-low reset
Cout  input  1  core output request; level, held until CioAcq is seen
CinReq  input  1  core input request; level, held until CioAcq is seen
CioAcq  output  1  acknowledge; single-cycle pulse per request
Data  input  DATA_DIGITS*DIGIT_WIDTH  BCD value to output; digit 0 in the LSBs
DataCin  output  DATA_DIGITS*DIGIT_WIDTH  BCD value of the last input byte
TxData  output  8  byte to the sink
TxValid  output  1  sink valid
TxReady  input  1  sink ready
RxData  input  8  byte from the source
RxValid  input  1  source valid
RxReady  output  1  high when the FIFO is not full
RxCount  output  $clog2(RX_DEPTH)+1  FIFO occupancy
BcdErr  output  1  sticky: a Data digit above 9 was seen at an output capture

Behaviour:
- Reset: CioAcq=0, DataCin=0, TxData=0, TxValid=0, BcdErr=0, FIFO empty (RxCount=0, RxReady=1), FSM in IDLE. Reset mid-transfer abandons the transfer; no partial CioAcq pulse.
- FSM states: IDLE, TX, ACK, RELEASE.
- IDLE, Cout=1: capture TxData = (d2*100 + d1*10 + d0) mod 256 from Data. Set TxValid=1 and go to TX.
  - Any captured digit above 9: set BcdErr; the arithmetic is still applied to the raw digit value.
- IDLE, CinReq=1 (and Cout=0) with FIFO not empty: pop one byte and load DataCin with its BCD form (hundreds, tens, units; 0..255). Go to ACK.
- IDLE, CinReq=1 with FIFO empty: stay in IDLE and keep waiting; no timeout.
- Cout and CinReq both high: Cout wins; CinReq is serviced only after RELEASE.
- TX: hold TxData and TxValid stable until TxValid&TxReady. On that edge, TxValid=0 and go to ACK.
- ACK: CioAcq=1 for exactly one cycle, then go to RELEASE.
- RELEASE: CioAcq=0. Stay until Cout=0 and CinReq=0 are both seen in the same cycle, then go to IDLE. This stops one request from being acknowledged twice.
- Latency with TxReady held high: Cout rises at edge N, TxValid at N+1, CioAcq at N+3.
- Latency for CinReq with data buffered: CioAcq one cycle after the pop edge; DataCin is valid from the pop edge.
- DataCin holds its value until the next pop.
- FIFO push: RxValid&RxReady. RxReady is combinational !full.
  - Push and pop in the same cycle are both honoured; RxCount is unchanged.
  - When full, no push happens and the source holds its byte.
  - Read and write pointers wrap modulo RX_DEPTH.
- Bytes are delivered in arrival order; none are dropped.

Optional Feature:
Macro CIO_ECHO_EN.
- Defined: every popped input byte is also sent to the sink before the acknowledge. The path becomes pop, then TX (TxData = raw popped byte), then ACK. The ACK therefore waits for TxReady.
- Undefined: input bytes are not echoed; the pop goes straight to ACK as described above. No TX activity on input.

Decomposition:
- Shared package holds:
  - the digit-count and width constants already used by the core;
  - the FSM state enum;
  - functions bcd3_to_byte and byte_to_bcd3.
- One sub-module, dpc_cio_fifo: parameterised RX_DEPTH x 8 synchronous FIFO with count, full and empty. It takes the same Clk and Rst_n.

Test Plan:
- Output: Data=BCD 072, TxReady=1, Cout held until CioAcq. Expect TxData=0x48, one TxValid beat, exactly one CioAcq pulse 3 cycles after Cout rises, FSM back in IDLE after Cout drops.
- Backpressure: TxReady=0 for 5 cycles, then 1. Expect TxData stable throughout, CioAcq only after the handshake cycle, and no second CioAcq while Cout stays high for 10 more cycles.
- Input: push bytes 0xFF then 0x07, then two CinReq requests. Expect DataCin=BCD 255 then BCD 007, one CioAcq per request, RxCount 2, 1, 0.
- Empty wait and overflow: CinReq with an empty FIFO gives no CioAcq. Then push 5 bytes with RX_DEPTH=4: the fifth is held (RxReady=0) until a pop, and all 5 arrive in order.
- Bad BCD: Data digits {0xA,0,0}. Expect BcdErr=1 (sticky until reset) and TxData=(1000 mod 256)=0xE8.
- With CIO_ECHO_EN, input 0x41: expect TxData=0x41 and TxValid before CioAcq, and DataCin=BCD 065.

Source files
------------

// File: rtl/dpc_console_io_pkg.sv
// Shared types and BCD helpers for the DekatronPC console I/O responder.
// Digit constants match the core's data dekatron layout.
package dpc_console_io_pkg;

  localparam int DATA_DEKATRON_NUM = 3;
  localparam int DEKATRON_WIDTH    = 4;
  localparam int DATA_W            = DATA_DEKATRON_NUM * DEKATRON_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_TX,
    ST_ACK,
    ST_RELEASE
  } cio_state_e;

  // Raw digit values are used even when above 9; the result wraps modulo 256.
  function automatic logic [7:0] bcd3_to_byte(input logic [DATA_W-1:0] d);
    return 8'(d[11:8]) * 8'd100 + 8'(d[7:4]) * 8'd10 + 8'(d[3:0]);
  endfunction

  function automatic logic [DATA_W-1:0] byte_to_bcd3(input logic [7:0] b);
    return {4'(b / 8'd100), 4'((b / 8'd10) % 8'd10), 4'(b % 8'd10)};
  endfunction

endpackage

// File: rtl/dpc_console_io_if.sv
// Core handshake plus byte-stream sink/source bundle for dpc_console_io.
// master = core/console side, slave = the responder.
interface dpc_console_io_if #(
  parameter int DATA_W = 12,
  parameter int CNT_W  = 3
);
  logic              Cout;
  logic              CinReq;
  logic              CioAcq;
  logic [DATA_W-1:0] Data;
  logic [DATA_W-1:0] DataCin;
  logic [7:0]        TxData;
  logic              TxValid;
  logic              TxReady;
  logic [7:0]        RxData;
  logic              RxValid;
  logic              RxReady;
  logic [CNT_W-1:0]  RxCount;
  logic              BcdErr;

  modport master (
    output Cout, CinReq, Data, TxReady, RxData, RxValid,
    input  CioAcq, DataCin, TxData, TxValid, RxReady, RxCount, BcdErr
  );

  modport slave (
    input  Cout, CinReq, Data, TxReady, RxData, RxValid,
    output CioAcq, DataCin, TxData, TxValid, RxReady, RxCount, BcdErr
  );
endinterface

// File: rtl/dpc_cio_fifo.sv
// Type-ahead byte FIFO for console input; RX_DEPTH must be a power of 2.
// Simultaneous push and pop are both honoured.
module dpc_cio_fifo #(
  parameter int RX_DEPTH = 4,
  parameter int CW       = $clog2(RX_DEPTH) + 1
) (
  input  logic          Clk,
  input  logic          Rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    wr_data,
  output logic [7:0]    rd_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);
  localparam int PW = $clog2(RX_DEPTH);

  logic [7:0]    mem [RX_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full    = (count == CW'(RX_DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge Clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end
endmodule

// File: rtl/dpc_console_io.sv
// Console I/O responder: BCD accumulator -> UART TX byte, UART RX byte -> BCD.
// Define CIO_ECHO_EN to echo every popped input byte to the sink before acking.
//
// state   | meaning
// IDLE    | waiting for Cout, or CinReq with a buffered byte
// TX      | TxValid held until the sink takes the byte
// ACK     | CioAcq pulse is registered on leaving this state
// RELEASE | waiting for Cout and CinReq to both drop
module dpc_console_io
  import dpc_console_io_pkg::*;
#(
  parameter int DATA_DIGITS = DATA_DEKATRON_NUM,
  parameter int DIGIT_WIDTH = DEKATRON_WIDTH,
  parameter int RX_DEPTH    = 4
) (
  input logic             Clk,
  input logic             Rst_n,
  dpc_console_io_if.slave cio
);
  localparam int CW = $clog2(RX_DEPTH) + 1;

  cio_state_e        state, state_nxt;
  logic [7:0]        tx_data, tx_data_nxt;
  logic              tx_valid, tx_valid_nxt;
  logic              cio_acq, cio_acq_nxt;
  logic [DATA_W-1:0] data_cin, data_cin_nxt;
  logic              bcd_err, bcd_err_nxt;
  logic              fifo_pop, fifo_full, fifo_empty, digit_bad;
  logic [7:0]        rx_byte;
  logic [CW-1:0]     rx_count;

  dpc_cio_fifo #(.RX_DEPTH(RX_DEPTH)) u_fifo (
    .Clk     (Clk),
    .Rst_n   (Rst_n),
    .push    (cio.RxValid),
    .pop     (fifo_pop),
    .wr_data (cio.RxData),
    .rd_data (rx_byte),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (rx_count)
  );

  assign cio.RxReady = ~fifo_full;
  assign cio.RxCount = rx_count;
  assign cio.CioAcq  = cio_acq;
  assign cio.TxData  = tx_data;
  assign cio.TxValid = tx_valid;
  assign cio.DataCin = data_cin;
  assign cio.BcdErr  = bcd_err;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state    <= ST_IDLE;
      tx_data  <= '0;
      tx_valid <= 1'b0;
      cio_acq  <= 1'b0;
      data_cin <= '0;
      bcd_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      tx_data  <= tx_data_nxt;
      tx_valid <= tx_valid_nxt;
      cio_acq  <= cio_acq_nxt;
      data_cin <= data_cin_nxt;
      bcd_err  <= bcd_err_nxt;
    end
  end

  always_comb begin
    digit_bad = 1'b0;
    for (int i = 0; i < DATA_DIGITS; i++) begin
      if (cio.Data[i*DIGIT_WIDTH +: DIGIT_WIDTH] > DIGIT_WIDTH'(9)) digit_bad = 1'b1;
    end
  end

  always_comb begin
    state_nxt    = state;
    tx_data_nxt  = tx_data;
    tx_valid_nxt = tx_valid;
    cio_acq_nxt  = 1'b0;
    data_cin_nxt = data_cin;
    bcd_err_nxt  = bcd_err;
    fifo_pop     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cio.Cout) begin
          tx_data_nxt  = bcd3_to_byte(cio.Data);
          tx_valid_nxt = 1'b1;
          if (digit_bad) bcd_err_nxt = 1'b1;
          state_nxt    = ST_TX;
        end else if (cio.CinReq && !fifo_empty) begin
          fifo_pop     = 1'b1;
          data_cin_nxt = byte_to_bcd3(rx_byte);
`ifdef CIO_ECHO_EN
          tx_data_nxt  = rx_byte;
          tx_valid_nxt = 1'b1;
          state_nxt    = ST_TX;
`else
          state_nxt    = ST_ACK;
`endif
        end
      end
      ST_TX: begin
        if (cio.TxReady) begin
          tx_valid_nxt = 1'b0;
          state_nxt    = ST_ACK;
        end
      end
      ST_ACK: begin
        cio_acq_nxt = 1'b1;
        state_nxt   = ST_RELEASE;
      end
      ST_RELEASE: begin
        // Both requests must be seen low together, so a held request is never acked twice.
        if (!cio.Cout && !cio.CinReq) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end
endmodule

// File: tb/tb_dpc_console_io.sv
// Bench for dpc_console_io: directed scenarios plus randomized core/UART traffic,
// all cycles checked against a transaction-level model of the responder.
module tb_dpc_console_io;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  logic [7:0] src_q[$];
  int   src_idx = 0;
  int   rdy_mode = 0;
  bit   rand_on = 1'b0;

  dpc_console_io_if #(.DATA_W(12), .CNT_W(3)) cio();

  dpc_console_io #(.DATA_DIGITS(3), .DIGIT_WIDTH(4), .RX_DEPTH(4)) dut (
    .Clk   (clk),
    .Rst_n (rst_n),
    .cio   (cio.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 30) $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] m_to_byte(input logic [11:0] d);
    int v;
    v = int'(d[11:8]) * 100 + int'(d[7:4]) * 10 + int'(d[3:0]);
    return 8'(v % 256);
  endfunction

  function automatic logic [11:0] m_to_bcd(input logic [7:0] b);
    int r, h, t;
    r = int'(b); h = 0; t = 0;
    while (r >= 100) begin r -= 100; h++; end
    while (r >= 10) begin r -= 10; t++; end
    return {4'(h), 4'(t), 4'(r)};
  endfunction

  function automatic bit m_bad(input logic [11:0] d);
    return (d[11:8] > 4'd9) || (d[7:4] > 4'd9) || (d[3:0] > 4'd9);
  endfunction

  // model state: FIFO contents, expected outputs, request progress
  logic [7:0]  mq[$];
  logic [7:0]  m_txd;
  logic [11:0] m_cin;
  bit          m_txv, m_acq, m_busy, m_rel, m_err;
  int          m_due;

  task automatic m_reset();
    mq.delete();
    m_txd = 0; m_cin = 0; m_txv = 0; m_acq = 0;
    m_busy = 0; m_rel = 0; m_err = 0; m_due = -1;
  endtask

  initial begin : mdl
    int         sz;
    bit         txv0, busy0;
    logic [7:0] b;
    m_reset();
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst_n) m_reset();
      else begin
        sz = mq.size(); txv0 = m_txv; busy0 = m_busy;
        m_acq = 0;
        if (m_due == cyc) begin
          m_acq = 1; m_rel = 1; m_due = -1;
        end else if (m_rel && !cio.Cout && !cio.CinReq) begin
          m_rel = 0; m_busy = 0;
        end
        if (txv0 && cio.TxReady) begin
          m_txv = 0; m_due = cyc + 1;
        end
        if (!busy0) begin
          if (cio.Cout) begin
            m_txd = m_to_byte(cio.Data);
            if (m_bad(cio.Data)) m_err = 1;
            m_txv = 1; m_busy = 1;
          end else if (cio.CinReq && sz > 0) begin
            b = mq.pop_front();
            m_cin = m_to_bcd(b);
`ifdef CIO_ECHO_EN
            m_txd = b; m_txv = 1;
`else
            m_due = cyc + 1;
`endif
            m_busy = 1;
          end
        end
        if (cio.RxValid && sz < 4) mq.push_back(cio.RxData);
      end
      @(negedge clk);
      if (!rst_n) m_reset();
      chk("acq", cio.CioAcq, m_acq);
      chk("txvalid", cio.TxValid, m_txv);
      chk("txdata", cio.TxData, m_txd);
      chk("datacin", cio.DataCin, m_cin);
      chk("rxcount", cio.RxCount, mq.size());
      chk("rxready", cio.RxReady, mq.size() < 4);
      chk("bcderr", cio.BcdErr, m_err);
    end
  end

  initial begin : src
    bit ok;
    cio.RxValid = 1'b0;
    cio.RxData  = '0;
    forever begin
      @(negedge clk);
      ok = cio.RxValid && cio.RxReady && rst_n;
      @(posedge clk);
      if (ok) src_idx++;
      #1;
      if (!(cio.RxValid && !ok)) begin
        if (src_idx < src_q.size() && (!rand_on || $urandom_range(0, 3) != 0)) begin
          cio.RxValid = 1'b1;
          cio.RxData  = src_q[src_idx];
        end else begin
          cio.RxValid = 1'b0;
        end
      end
    end
  end

  initial begin : snk
    cio.TxReady = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       cio.TxReady = 1'b1;
        1:       cio.TxReady = 1'b0;
        default: cio.TxReady = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial begin : wdog
    #600000;
    $display("FAIL watchdog: run did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_acq(input int lim, output int at, output bit sv, output logic [7:0] td);
    sv = 0; td = 0; at = -1;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (cio.TxValid) begin sv = 1; td = cio.TxData; end
      if (cio.CioAcq) begin at = cyc; break; end
    end
    chk("acq_seen", cio.CioAcq, 1);
  endtask

  task automatic cout_req(input logic [11:0] d, output logic [7:0] td);
    int at; bit sv;
    step();
    cio.Data = d; cio.Cout = 1'b1;
    wait_acq(100, at, sv, td);
    step();
    cio.Cout = 1'b0;
    step();
  endtask

  task automatic cin_req(output logic [11:0] got, output bit sv, output logic [7:0] td);
    int at;
    step();
    cio.CinReq = 1'b1;
    wait_acq(200, at, sv, td);
    got = cio.DataCin;
    step();
    cio.CinReq = 1'b0;
    step();
  endtask

  function automatic logic [11:0] rand_data();
    logic [3:0] dg[3];
    for (int i = 0; i < 3; i++) begin
      dg[i] = 4'($urandom_range(0, 9));
      if ($urandom_range(0, 15) == 0) dg[i] = 4'($urandom_range(10, 15));
    end
    return {dg[2], dg[1], dg[0]};
  endfunction

  initial begin : main
    int          at, n0, extra, nhold;
    bit          sv;
    logic [7:0]  td;
    logic [11:0] got;
    logic [11:0] exp4[5];
    exp4 = '{12'h016, 12'h017, 12'h018, 12'h019, 12'h020};
    cio.Cout = 1'b0; cio.CinReq = 1'b0; cio.Data = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rxready", cio.RxReady, 1);
    chk("rst_rxcount", cio.RxCount, 0);
    step();
    rst_n = 1'b1;
    step();

    // output 072 with the sink always ready
    step();
    cio.Data = 12'h072; cio.Cout = 1'b1; n0 = cyc;
    wait_acq(50, at, sv, td);
    chk("t1_txdata", td, 8'h48);
    chk("t1_latency", at - n0, 3);
    step(); cio.Cout = 1'b0; step(); step();

    // sink backpressure, then Cout held long after the ack
    rdy_mode = 1; step(); step();
    cio.Data = 12'h123; cio.Cout = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t2_noacq", cio.CioAcq, 0);
      if (i >= 1) chk("t2_hold", {cio.TxValid, cio.TxData}, {1'b1, 8'h7B});
    end
    rdy_mode = 0;
    wait_acq(50, at, sv, td);
    extra = 0;
    repeat (10) begin @(negedge clk); if (cio.CioAcq) extra++; end
    chk("t2_single_ack", extra, 0);
    step(); cio.Cout = 1'b0; step(); step();

    // two buffered input bytes
    src_q.push_back(8'hFF); src_q.push_back(8'h07);
    repeat (6) step();
    chk("t3_count2", cio.RxCount, 2);
    cin_req(got, sv, td);
    chk("t3_bcd255", got, 12'h255);
    chk("t3_count1", cio.RxCount, 1);
    cin_req(got, sv, td);
    chk("t3_bcd007", got, 12'h007);
    chk("t3_count0", cio.RxCount, 0);

    // input request with nothing buffered, then overfill by one
    step(); cio.CinReq = 1'b1;
    extra = 0;
    repeat (10) begin @(negedge clk); if (cio.CioAcq) extra++; end
    chk("t4_empty_noack", extra, 0);
    step(); cio.CinReq = 1'b0; step();
    for (int b = 16; b < 21; b++) src_q.push_back(8'(b));
    repeat (12) step();
    chk("t4_full_count", cio.RxCount, 4);
    chk("t4_full_rdy", cio.RxReady, 0);
    for (int k = 0; k < 5; k++) begin
      cin_req(got, sv, td);
      chk("t4_order", got, exp4[k]);
    end

    // invalid BCD digit
    cout_req(12'hA00, td);
    chk("t5_txdata", td, 8'hE8);
    chk("t5_err", cio.BcdErr, 1);
    cout_req(12'h001, td);
    chk("t5_sticky", cio.BcdErr, 1);

    // input 0x41, echoed when the echo option is built in
    src_q.push_back(8'h41);
    repeat (4) step();
    cin_req(got, sv, td);
    chk("t6_bcd065", got, 12'h065);
`ifdef CIO_ECHO_EN
    chk("t6_echo_valid", sv, 1);
    chk("t6_echo_data", td, 8'h41);
`else
    chk("t6_no_echo", sv, 0);
`endif

    // randomized traffic
    rand_on = 1; rdy_mode = 2;
    for (int t = 0; t < 250; t++) begin
      int r;
      r = $urandom_range(0, 9);
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 3)) src_q.push_back(8'($urandom_range(0, 255)));
      end
      if (r >= 4 && src_idx >= src_q.size() && cio.RxCount == 0)
        src_q.push_back(8'($urandom_range(0, 255)));
      step();
      cio.Data = rand_data();
      cio.Cout = (r < 4) || (r >= 8);
      cio.CinReq = (r >= 4);
      wait_acq(300, at, sv, td);
      nhold = $urandom_range(0, 3);
      repeat (nhold) step();
      step();
      cio.Cout = 1'b0; cio.CinReq = 1'b0;
      repeat ($urandom_range(0, 2)) step();
    end
    rand_on = 0; rdy_mode = 0;
    for (int i = 0; i < 50 && src_idx < src_q.size(); i++) step();

    // reset while a byte is stuck waiting for the sink
    rdy_mode = 1; step(); step();
    cio.Data = 12'h250; cio.Cout = 1'b1;
    repeat (3) step();
    rst_n = 1'b0;
    step();
    cio.Cout = 1'b0;
    step(); step();
    rst_n = 1'b1;
    rdy_mode = 0;
    extra = 0;
    repeat (8) begin @(negedge clk); if (cio.CioAcq) extra++; end
    chk("t7_no_partial_ack", extra, 0);
    chk("t7_err_cleared", cio.BcdErr, 0);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
